uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_receiver.sv | 169 ++++++++++++++++
 tb/tb_uart_receiver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encoding and shared constants (receiver and transmitter)
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling 8-bit UART receiver
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int MID_SAMPLE = 7
) (
  input  logic                 bot_clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_status,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 w_rx;
  logic                 w_tick_end;
  uart_state_e          r_state,  w_state_nxt;
  logic [3:0]           r_tick,   w_tick_nxt;
  logic [2:0]           r_bit,    w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
  logic [DATA_BITS-1:0] r_data,   w_data_nxt;
  logic                 r_status, w_status_nxt;
  logic                 r_ferr,   w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad, w_par_bad_nxt;
  logic                 r_perr,    w_perr_nxt;
`endif

  uart_rx_sync u_sync (
    .i_clk   (bot_clk),
    .i_rst_n (reset),
    .i_d     (uart_rx),
    .o_q     (w_rx)
  );

  assign w_tick_end = (r_tick == TICK_LAST);

  always_ff @(posedge bot_clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_tick   <= 4'd0;
      r_bit    <= 3'd0;
      r_shift  <= '0;
      r_data   <= '0;
      r_status <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_status <= w_status_nxt;
      r_ferr   <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick + 4'd1;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_data;
    w_status_nxt = 1'b0;
    w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_perr_nxt    = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        w_tick_nxt = 4'd0;
        w_bit_nxt  = 3'd0;
        if (!w_rx) begin
          w_state_nxt = ST_START;
        end
      end

      // Counting restarts at start-bit middle, so later samples land mid-bit.
      ST_START: begin
        if (r_tick == TICK_MID) begin
          w_tick_nxt  = 4'd0;
          w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_tick_end) begin
          w_tick_nxt  = 4'd0;
          w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick_end) begin
          w_tick_nxt    = 4'd0;
          w_par_bad_nxt = w_rx ^ (^r_shift);
          w_state_nxt   = ST_STOP;
        end
      end
`endif

      // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
      ST_STOP: begin
        if (w_tick_end) begin
          w_tick_nxt = 4'd0;
          if (w_rx) begin
            w_data_nxt   = r_shift;
            w_status_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt   = r_par_bad;
`endif
            w_state_nxt  = ST_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        w_tick_nxt = 4'd0;
        if (w_rx) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_tick_nxt  = 4'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign rx_data   = r_data;
  assign rx_status = r_status;
  assign frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver (honours UART_RX_PARITY_EN)
module tb_uart_receiver;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT        = 170;
  localparam int FRAME_BITS = 11;
`else
  localparam int LAT        = 154;
  localparam int FRAME_BITS = 10;
`endif

  logic       bot_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       parity_err;

  uart_receiver #(.OVERSAMPLE(16), .MID_SAMPLE(7)) dut (
    .bot_clk    (bot_clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_status  (rx_status),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 bot_clk = ~bot_clk;

  int cyc = 0;
  always @(posedge bot_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   ferr_q[$];
  int   pulse_cyc[$];
  int   errors = 0;
  int   checks = 0;
  exp_t mon_e;
  int   mon_due;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_window(input string name, input int act, input int req);
    checks++;
    if (act < req - 2 || act > req + 2) begin
      errors++;
      $display("FAIL %s: cycle %0d, expected %0d +/-2", name, act, req);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge bot_clk) begin
    if (reset) begin
      if (rx_status) begin
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx_status: rx_data=0x%0h at cycle %0d, expected none", rx_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(mon_e.data));
          check("parity_err", 32'(parity_err), 32'(mon_e.perr));
          check_window("rx_status_latency", cyc, mon_e.due);
        end
      end else if (parity_err) begin
        checks++;
        errors++;
        $display("FAIL lone_parity_err: parity_err=1 without rx_status at cycle %0d, expected 0", cyc);
      end
      if (frame_err) begin
        if (ferr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_err: frame_err=1 at cycle %0d, expected 0", cyc);
        end else begin
          mon_due = ferr_q.pop_front();
          check_window("frame_err_latency", cyc, mon_due);
        end
      end
    end
  end

  task automatic ticks(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge bot_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    exp_t e;
    if (stop_v) begin
      e.data = d;
      e.perr = par_flip;
      e.due  = cyc + LAT;
      exp_q.push_back(e);
    end else begin
      ferr_q.push_back(cyc + LAT);
    end
    ticks(1'b0, OS);
    for (int i = 0; i < 8; i++) ticks(d[i], OS);
`ifdef UART_RX_PARITY_EN
    ticks((^d) ^ par_flip, OS);
`endif
    ticks(stop_v, OS);
  endtask

  int n_pulses;

  initial begin
    repeat (3) @(posedge bot_clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_status", 32'(rx_status), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    reset = 1'b1;
    ticks(1'b1, 20);

    send_frame(8'hA5, 1'b1, 1'b0);
    ticks(1'b1, 8);
    check("a5_held", 32'(rx_data), 32'hA5);

    // Short low glitch must be rejected at mid start bit.
    ticks(1'b0, 4);
    ticks(1'b1, 40);
    send_frame(8'h3C, 1'b1, 1'b0);
    ticks(1'b1, 8);

    // Stop bit low, then line held low: one frame_err, no new frame.
    send_frame(8'h55, 1'b0, 1'b0);
    ticks(1'b0, 40);
    check("hold_after_frame_err", 32'(rx_data), 32'h3C);
    ticks(1'b1, 32);
    send_frame(8'h5A, 1'b1, 1'b0);
    ticks(1'b1, 8);

    n_pulses = pulse_cyc.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    ticks(1'b1, 8);
    check("b2b_pulse_count", 32'(pulse_cyc.size() - n_pulses), 32'd2);
    if (pulse_cyc.size() == n_pulses + 2)
      check("b2b_spacing", 32'(pulse_cyc[n_pulses+1] - pulse_cyc[n_pulses]), 32'(FRAME_BITS * OS));
    check("b2b_last_data", 32'(rx_data), 32'hFF);

    // 0x81 aborted by reset in the middle of data bit 4.
    ticks(1'b0, OS);
    ticks(1'b1, OS);
    ticks(1'b0, 3 * OS);
    ticks(1'b0, 8);
    reset = 1'b0;
    ticks(1'b0, 3);
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    check("midreset_rx_status", 32'(rx_status), 32'd0);
    ticks(1'b1, 2);
    reset = 1'b1;
    ticks(1'b1, 32);
    check("after_reset_rx_data", 32'(rx_data), 32'h00);
    send_frame(8'h81, 1'b1, 1'b0);
    ticks(1'b1, 8);
    check("81_held", 32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    ticks(1'b1, 8);
    check("parity_frame_data", 32'(rx_data), 32'h07);
`endif

    ticks(1'b1, 20);
    check("rx_status_all_seen", 32'(exp_q.size()), 32'd0);
    check("frame_err_all_seen", 32'(ferr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
